// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: round constants, initial hash value, word types
// and the bitwise helper functions used by the round and schedule logic.
package sha256_pkg;

    typedef logic [31:0] word_t;
    // Word vector with [7] = a/H0 down to [0] = h/H7, matching the port bit order.
    typedef logic [7:0][31:0] hash_t;

    typedef enum logic [1:0] {S_IDLE, S_ROUND, S_FINAL, S_DONE} state_t;

    localparam word_t K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam hash_t IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    function automatic word_t rotr(input word_t x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic word_t ch(input word_t e, input word_t f, input word_t g);
        return (e & f) | (~e & g);
    endfunction

    function automatic word_t maj(input word_t a, input word_t b, input word_t c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    function automatic word_t big_sigma0(input word_t x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic word_t big_sigma1(input word_t x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic word_t small_sigma0(input word_t x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic word_t small_sigma1(input word_t x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

endpackage

// File: rtl/sha256_msg_sched.sv
// 16-word sliding message-schedule window; w_o[j] is W[t+j] for the rounds
// evaluated this cycle, and the window slides by ROUNDS_PER_CYCLE on advance.
module sha256_msg_sched
    import sha256_pkg::*;
#(
    parameter int ROUNDS_PER_CYCLE = 1
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              load_i,
    input  logic                              advance_i,
    input  logic [511:0]                      block_i,
    output logic [ROUNDS_PER_CYCLE-1:0][31:0] w_o
);

    word_t win_q [16];
    word_t win_d [16];

    always_comb begin : sched_next
        word_t ext [16 + ROUNDS_PER_CYCLE];
        for (int i = 0; i < 16; i++) ext[i] = win_q[i];
        // New words may depend on words generated earlier in the same cycle.
        for (int j = 0; j < ROUNDS_PER_CYCLE; j++) begin
            ext[16 + j] = small_sigma1(ext[14 + j]) + ext[9 + j] + small_sigma0(ext[1 + j]) + ext[j];
        end
        for (int i = 0; i < 16; i++) win_d[i] = ext[i + ROUNDS_PER_CYCLE];
        for (int j = 0; j < ROUNDS_PER_CYCLE; j++) w_o[j] = win_q[j];
    end

    // NOTE: the window is reset explicitly because its contents are part of the
    // defined reset state; it is small enough to live in flops, not a RAM.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) win_q[i] <= '0;
        end else if (load_i) begin
            for (int i = 0; i < 16; i++) win_q[i] <= block_i[511 - 32*i -: 32];
        end else if (advance_i) begin
            win_q <= win_d;
        end
    end

endmodule

// File: rtl/sha256_compress_engine.sv
// Iterative SHA-256 compression: accepts a block plus chaining value, runs the
// 64 rounds ROUNDS_PER_CYCLE at a time, then presents the updated digest.
module sha256_compress_engine
    import sha256_pkg::*;
#(
    parameter int ROUNDS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         block_valid,
    output logic         block_ready,
    input  logic [511:0] block_data,
    input  logic [255:0] hash_in,
    output logic         digest_valid,
    input  logic         digest_ready,
    output logic [255:0] digest
);

    localparam logic [6:0] ROUNDS_DONE = 7'd64;

    state_t     state_q, state_d;
    logic [6:0] cnt_q, cnt_d;
    hash_t      work_q, work_d;
    hash_t      saved_q, saved_d;
    hash_t      digest_q, digest_d;
    hash_t      round_out;
    logic       accept;
    logic       advance;
    logic [ROUNDS_PER_CYCLE-1:0][31:0] w_cur;

    assign accept  = (state_q == S_IDLE) && block_valid;
    assign advance = (state_q == S_ROUND) && (cnt_q != ROUNDS_DONE);

    sha256_msg_sched #(.ROUNDS_PER_CYCLE(ROUNDS_PER_CYCLE)) u_sched (
        .clk       (clk),
        .reset     (reset),
        .load_i    (accept),
        .advance_i (advance),
        .block_i   (block_data),
        .w_o       (w_cur)
    );

    // NOTE: blocking assignments are intentional here: each chained round must
    // see the previous round's a..h within the same cycle.
    always_comb begin : round_logic
        word_t a, b, c, d, e, f, g, h, t1, t2;
        logic [5:0] t;
        {a, b, c, d, e, f, g, h} = work_q;
        for (int j = 0; j < ROUNDS_PER_CYCLE; j++) begin
            t  = cnt_q[5:0] + 6'(j);
            t1 = h + big_sigma1(e) + ch(e, f, g) + K[t] + w_cur[j];
            t2 = big_sigma0(a) + maj(a, b, c);
            h  = g;
            g  = f;
            f  = e;
            e  = d + t1;
            d  = c;
            c  = b;
            b  = a;
            a  = t1 + t2;
        end
        round_out = {a, b, c, d, e, f, g, h};
    end

    // NOTE: every next-state signal gets its hold value first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin : fsm_next
        state_d  = state_q;
        cnt_d    = cnt_q;
        work_d   = work_q;
        saved_d  = saved_q;
        digest_d = digest_q;
        case (state_q)
            S_IDLE: begin
                if (block_valid) begin
                    saved_d = hash_in;
                    work_d  = hash_in;
                    cnt_d   = '0;
                    state_d = S_ROUND;
                end
            end
            S_ROUND: begin
                if (cnt_q == ROUNDS_DONE) begin
                    state_d = S_FINAL;
                end else begin
                    work_d = round_out;
                    cnt_d  = cnt_q + 7'(ROUNDS_PER_CYCLE);
                end
            end
            S_FINAL: begin
                for (int i = 0; i < 8; i++) digest_d[i] = saved_q[i] + work_q[i];
                cnt_d   = '0;
                state_d = S_DONE;
            end
            S_DONE: begin
                if (digest_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            work_q   <= '0;
            saved_q  <= '0;
            digest_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            work_q   <= work_d;
            saved_q  <= saved_d;
            digest_q <= digest_d;
        end
    end

    assign block_ready  = (state_q == S_IDLE);
    assign digest_valid = (state_q == S_DONE);
    assign digest       = digest_q;

endmodule
